// File: rtl/lcd_spi_arbiter_pkg.sv
// Shared types and constants for the LCD SPI word arbiter.
package lcd_spi_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWaitDone,
    StGap
  } state_e;

  localparam logic DcCmd  = 1'b0;
  localparam logic DcData = 1'b1;

  localparam int unsigned DefaultGapCycles     = 2;
  localparam int unsigned DefaultTimeoutCycles = 4096;

endpackage

// File: rtl/lcd_spi_arbiter_rr_arb2.sv
// Two-request round-robin grant; bit 0 is the command port, bit 1 the pixel port.
module lcd_spi_arbiter_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // High when port 1 held the most recent grant; reset favours port 0.
  logic last_q;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (en && (gnt != 2'b00)) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/lcd_spi_arbiter.sv
// Arbitrates command and pixel words onto a single 16-bit SPI word transmitter.
module lcd_spi_arbiter
  import lcd_spi_arbiter_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = DefaultGapCycles,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_req,
  input  logic [15:0] i_cmd_word,
  input  logic        i_cmd_dc,
  output logic        o_cmd_ack,
  input  logic        i_pix_req,
  input  logic [15:0] i_pix_word,
  output logic        o_pix_ack,
  output logic [15:0] o_spi_data,
  output logic        o_spi_we,
  input  logic        i_spi_done,
  output logic        o_dc,
  output logic        o_busy,
  output logic        o_timeout
);

  localparam logic [15:0] GapLimit     = 16'(GAP_CYCLES);
  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [15:0] data_q, data_d;
  logic        dc_q, dc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  logic        done_q, done_prev_q;
  logic [1:0]  gnt;

  lcd_spi_arbiter_rr_arb2 u_arb (
    .clk (i_clk),
    .rst (i_rst),
    .req ({i_pix_req, i_cmd_req}),
    .en  (state_q == StIdle),
    .gnt (gnt)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    dc_d      = dc_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    o_cmd_ack = 1'b0;
    o_pix_ack = 1'b0;
    o_spi_we  = 1'b0;
    case (state_q)
      StIdle: begin
        if (gnt[0]) begin
          data_d    = i_cmd_word;
          dc_d      = i_cmd_dc;
          o_cmd_ack = 1'b1;
          state_d   = StLoad;
        end else if (gnt[1]) begin
          data_d    = i_pix_word;
          dc_d      = DcData;
          o_pix_ack = 1'b1;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        o_spi_we = 1'b1;
        cnt_d    = '0;
        state_d  = StWaitDone;
      end
      StWaitDone: begin
        cnt_d = cnt_q + 16'd1;
        // A completion edge wins over a timeout landing in the same cycle.
        if (done_q && !done_prev_q) begin
          cnt_d   = '0;
          state_d = StGap;
        end else if (cnt_q + 16'd1 == TimeoutLimit) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = StGap;
        end
      end
      StGap: begin
        // A zero gap still spends one cycle here before returning to idle.
        if (cnt_q + 16'd1 >= GapLimit) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      data_q      <= 16'h0000;
      dc_q        <= DcCmd;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      done_q      <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      dc_q        <= dc_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      done_q      <= i_spi_done;
      done_prev_q <= done_q;
    end
  end

  assign o_spi_data = data_q;
  assign o_dc       = dc_q;
  assign o_busy     = (state_q != StIdle);
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_lcd_spi_arbiter.sv
// Directed bench for lcd_spi_arbiter with a two-cycle-latency transmitter model.
module tb_lcd_spi_arbiter;

  logic        clk;
  logic        rst;
  logic        cmd_req;
  logic [15:0] cmd_word;
  logic        cmd_dc;
  logic        cmd_ack;
  logic        pix_req;
  logic [15:0] pix_word;
  logic        pix_ack;
  logic [15:0] spi_data;
  logic        spi_we;
  logic        spi_done;
  logic        dc;
  logic        busy;
  logic        timeout;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int tx_mode = 0;  // 0: auto-completing model, 1: bench drives spi_done by hand
  int tx_cd  = 0;

  lcd_spi_arbiter #(
    .GAP_CYCLES     (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_cmd_req  (cmd_req),
    .i_cmd_word (cmd_word),
    .i_cmd_dc   (cmd_dc),
    .o_cmd_ack  (cmd_ack),
    .i_pix_req  (pix_req),
    .i_pix_word (pix_word),
    .o_pix_ack  (pix_ack),
    .o_spi_data (spi_data),
    .o_spi_we   (spi_we),
    .i_spi_done (spi_done),
    .o_dc       (dc),
    .o_busy     (busy),
    .o_timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Transmitter: done pulses for one cycle two negedges after the write strobe.
  initial forever begin
    @(negedge clk);
    if (tx_mode == 0) begin
      spi_done = 1'b0;
      if (tx_cd > 0) begin
        tx_cd--;
        if (tx_cd == 0) spi_done = 1'b1;
      end
      if (spi_we) tx_cd = 2;
    end else begin
      tx_cd = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int budget, output int n);
    n = 0;
    #1;
    while (!(cmd_ack || pix_ack) && n < budget) begin
      step();
      n++;
    end
    check("ack_within_budget", 32'(cmd_ack | pix_ack), 32'd1);
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    check("idle_within_budget", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int acks_seen;
    int prev_ack;
    logic [15:0] pix_words [3];
    pix_words[0] = 16'h001F;
    pix_words[1] = 16'h07E0;
    pix_words[2] = 16'hF800;

    rst = 1'b1; cmd_req = 1'b0; cmd_word = '0; cmd_dc = 1'b0;
    pix_req = 1'b0; pix_word = '0; spi_done = 1'b0;
    do_reset();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_we", 32'(spi_we), 32'd0);
    check("rst_data", 32'(spi_data), 32'h0);
    check("rst_dc", 32'(dc), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_acks", 32'({cmd_ack, pix_ack}), 32'd0);

    // Single command word.
    cmd_word = 16'h3E28; cmd_dc = 1'b0; cmd_req = 1'b1;
    wait_ack(4, n);
    check("t1_cmd_ack", 32'(cmd_ack), 32'd1);
    check("t1_pix_ack", 32'(pix_ack), 32'd0);
    step();
    cmd_req = 1'b0;
    check("t1_we", 32'(spi_we), 32'd1);
    check("t1_data", 32'(spi_data), 32'h3E28);
    check("t1_dc", 32'(dc), 32'd0);
    check("t1_ack_one_cycle", 32'(cmd_ack), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    wait_idle(50, n);
    check("t1_busy_len", 32'(n), 32'd6);

    // Both ports held: strict alternation starting with command.
    do_reset();
    cmd_word = 16'h002C; cmd_dc = 1'b0; cmd_req = 1'b1;
    pix_word = 16'hF800; pix_req = 1'b1;
    prev_ack = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ack(20, n);
      check("t2_order_cmd", 32'(cmd_ack), (k % 2 == 0) ? 32'd1 : 32'd0);
      check("t2_order_pix", 32'(pix_ack), (k % 2 == 0) ? 32'd0 : 32'd1);
      if (k > 0) check("t2_ack_spacing", 32'(cycle - prev_ack), 32'd7);
      prev_ack = cycle;
      step();
      if (k == 3) begin
        cmd_req = 1'b0;
        pix_req = 1'b0;
      end
      check("t2_we", 32'(spi_we), 32'd1);
      check("t2_data", 32'(spi_data), (k % 2 == 0) ? 32'h002C : 32'hF800);
      check("t2_dc", 32'(dc), (k % 2 == 0) ? 32'd0 : 32'd1);
    end
    wait_idle(50, n);

    // Pixel-only stream; granted even though pixel was last.
    pix_word = pix_words[0]; pix_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_ack(20, n);
      check("t3_pix_ack", 32'(pix_ack), 32'd1);
      check("t3_cmd_ack", 32'(cmd_ack), 32'd0);
      step();
      if (k < 2) pix_word = pix_words[k+1];
      else pix_req = 1'b0;
      check("t3_we", 32'(spi_we), 32'd1);
      check("t3_data", 32'(spi_data), 32'(pix_words[k]));
      check("t3_dc", 32'(dc), 32'd1);
    end
    wait_idle(50, n);

    // Transmitter never completes: timeout, then the held pixel word is served.
    tx_mode = 1; spi_done = 1'b0;
    cmd_word = 16'h1234; cmd_dc = 1'b1; cmd_req = 1'b1;
    wait_ack(4, n);
    step();
    cmd_req = 1'b0;
    check("t4_we", 32'(spi_we), 32'd1);
    tx_mode = 0;
    pix_word = 16'hBEEF; pix_req = 1'b1;
    n = 0; acks_seen = 0;
    do begin
      step();
      n++;
      if (cmd_ack || pix_ack) acks_seen++;
    end while (!timeout && n < 40);
    check("t4_timeout_latency", 32'(n), 32'd17);
    check("t4_no_ack_while_busy", 32'(acks_seen), 32'd0);
    wait_ack(10, n);
    check("t4_pix_after_timeout", 32'(pix_ack), 32'd1);
    check("t4_gap_after_timeout", 32'(n), 32'd2);
    step();
    pix_req = 1'b0;
    check("t4_pix_data", 32'(spi_data), 32'hBEEF);
    wait_idle(50, n);
    check("t4_timeout_sticky", 32'(timeout), 32'd1);

    // Reset in WAIT_DONE aborts the word and restores command priority.
    tx_mode = 1; spi_done = 1'b0;
    cmd_word = 16'h5A5A; cmd_dc = 1'b1; cmd_req = 1'b1;
    wait_ack(4, n);
    step();
    cmd_req = 1'b0;
    step();
    check("t5_in_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_we", 32'(spi_we), 32'd0);
    check("t5_data", 32'(spi_data), 32'h0);
    check("t5_dc", 32'(dc), 32'd0);
    check("t5_timeout", 32'(timeout), 32'd0);
    tx_mode = 0;
    cmd_word = 16'h1111; cmd_dc = 1'b0; cmd_req = 1'b1;
    pix_word = 16'h2222; pix_req = 1'b1;
    wait_ack(4, n);
    check("t5_cmd_first", 32'({cmd_ack, pix_ack}), 32'b10);
    step();
    cmd_req = 1'b0;
    check("t5_cmd_data", 32'(spi_data), 32'h1111);
    wait_ack(20, n);
    check("t5_pix_second", 32'({cmd_ack, pix_ack}), 32'b01);
    step();
    pix_req = 1'b0;
    wait_idle(50, n);

    // Done held high as a level: second word needs a fresh rising edge.
    tx_mode = 1; spi_done = 1'b0;
    cmd_word = 16'hAAAA; cmd_dc = 1'b0; cmd_req = 1'b1;
    wait_ack(4, n);
    step();
    cmd_req = 1'b0;
    step();
    spi_done = 1'b1;
    wait_idle(20, n);
    cmd_word = 16'hBBBB; cmd_dc = 1'b1; cmd_req = 1'b1;
    wait_ack(4, n);
    step();
    cmd_req = 1'b0;
    check("t6_data", 32'(spi_data), 32'hBBBB);
    for (int k = 0; k < 8; k++) step();
    check("t6_still_waiting", 32'(busy), 32'd1);
    check("t6_no_timeout", 32'(timeout), 32'd0);
    check("t6_dc_held", 32'(dc), 32'd1);
    step();
    spi_done = 1'b0;
    step();
    spi_done = 1'b1;
    wait_idle(20, n);
    check("t6_edge_to_idle", 32'(n), 32'd4);
    spi_done = 1'b0;
    tx_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
